// File: rtl/regfile_sb_pkg.sv
// Shared defaults and address-validity helper for the parametrised register file.
package regfile_sb_pkg;

    localparam int unsigned RF_DATA_WIDTH = 32;
    localparam int unsigned RF_NUM_REGS   = 32;
    localparam int unsigned RF_ADDR_WIDTH = 5;
    localparam bit          RF_ZERO_REG   = 1'b1;
    localparam bit          RF_BYPASS     = 1'b1;
    localparam int unsigned RF_DBG_REG    = 1;

    // An address selects real storage only if it is in range and is not a hardwired r0.
    function automatic logic rf_addr_ok(input int unsigned addr,
                                        input int unsigned num_regs,
                                        input bit          zero_reg);
        return (addr < num_regs) && !(zero_reg && (addr == 0));
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback/hazard-side bundle of the register file with scoreboard.
interface regfile_sb_if
    import regfile_sb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int unsigned NUM_REGS   = RF_NUM_REGS
);

    logic                  ctrl_writeEnable;
    logic [ADDR_WIDTH-1:0] ctrl_writeReg;
    logic [DATA_WIDTH-1:0] data_writeReg;
    logic [ADDR_WIDTH-1:0] ctrl_readRegA;
    logic [ADDR_WIDTH-1:0] ctrl_readRegB;
    logic [DATA_WIDTH-1:0] data_readRegA;
    logic [DATA_WIDTH-1:0] data_readRegB;
    logic                  ctrl_issueEnable;
    logic [ADDR_WIDTH-1:0] ctrl_issueReg;
    logic                  ctrl_flush;
    logic                  busy_readRegA;
    logic                  busy_readRegB;
    logic [NUM_REGS-1:0]   busy_vector;
    logic [DATA_WIDTH-1:0] data_regDbg;

    modport master (
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output ctrl_readRegA, ctrl_readRegB,
        output ctrl_issueEnable, ctrl_issueReg, ctrl_flush,
        input  data_readRegA, data_readRegB,
        input  busy_readRegA, busy_readRegB, busy_vector, data_regDbg
    );

    modport slave (
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  ctrl_readRegA, ctrl_readRegB,
        input  ctrl_issueEnable, ctrl_issueReg, ctrl_flush,
        output data_readRegA, data_readRegB,
        output busy_readRegA, busy_readRegB, busy_vector, data_regDbg
    );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Pending-bit array: flush clears everything, otherwise issue-set beats write-clear.
module regfile_sb_scoreboard #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  i_issue_en,
    input  logic [ADDR_WIDTH-1:0] i_issue_reg,
    input  logic                  i_clr_en,
    input  logic [ADDR_WIDTH-1:0] i_clr_reg,
    input  logic                  i_flush,
    output logic [NUM_REGS-1:0]   o_pending
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_pending_nxt;

    always_comb begin
        w_pending_nxt = r_pending;
        if (i_flush) begin
            w_pending_nxt = '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (i_clr_en && (i_clr_reg == ADDR_WIDTH'(i)))
                    w_pending_nxt[i] = 1'b0;
                // Applied after the clear so a same-cycle reissue stays outstanding.
                if (i_issue_en && (i_issue_reg == ADDR_WIDTH'(i)))
                    w_pending_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset)
            r_pending <= '0;
        else
            r_pending <= w_pending_nxt;
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/regfile_sb.sv
// Register file: 2 async read ports with write bypass, 1 sync write port, scoreboard and debug tap.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned NUM_REGS   = RF_NUM_REGS,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter bit          ZERO_REG   = RF_ZERO_REG,
    parameter bit          BYPASS     = RF_BYPASS,
    parameter int unsigned DBG_REG    = RF_DBG_REG
) (
    input  logic       clock,
    input  logic       ctrl_reset,
    regfile_sb_if.slave rf
);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   w_pending;
    logic                  w_wr_ok;
    logic                  w_iss_ok;
    logic                  w_rda_ok;
    logic                  w_rdb_ok;
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;
    logic                  w_busy_a;
    logic                  w_busy_b;

    assign w_wr_ok  = rf.ctrl_writeEnable && rf_addr_ok(32'(rf.ctrl_writeReg), NUM_REGS, ZERO_REG);
    assign w_iss_ok = rf.ctrl_issueEnable && rf_addr_ok(32'(rf.ctrl_issueReg), NUM_REGS, ZERO_REG);
    assign w_rda_ok = rf_addr_ok(32'(rf.ctrl_readRegA), NUM_REGS, ZERO_REG);
    assign w_rdb_ok = rf_addr_ok(32'(rf.ctrl_readRegB), NUM_REGS, ZERO_REG);

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                if (w_wr_ok && (rf.ctrl_writeReg == ADDR_WIDTH'(i)))
                    r_regs[i] <= rf.data_writeReg;
        end
    end

    regfile_sb_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clock       (clock),
        .ctrl_reset  (ctrl_reset),
        .i_issue_en  (w_iss_ok),
        .i_issue_reg (rf.ctrl_issueReg),
        .i_clr_en    (w_wr_ok),
        .i_clr_reg   (rf.ctrl_writeReg),
        .i_flush     (rf.ctrl_flush),
        .o_pending   (w_pending)
    );

    // Read muxes; a forwarded write also hides the pending flag since the data is already here.
    always_comb begin
        w_rd_a   = '0;
        w_rd_b   = '0;
        w_busy_a = 1'b0;
        w_busy_b = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rf.ctrl_readRegA == ADDR_WIDTH'(i)) begin
                w_rd_a   = r_regs[i];
                w_busy_a = w_pending[i];
            end
            if (rf.ctrl_readRegB == ADDR_WIDTH'(i)) begin
                w_rd_b   = r_regs[i];
                w_busy_b = w_pending[i];
            end
        end
        if (!w_rda_ok) begin
            w_rd_a   = '0;
            w_busy_a = 1'b0;
        end else if (BYPASS && w_wr_ok && (rf.ctrl_writeReg == rf.ctrl_readRegA)) begin
            w_rd_a   = rf.data_writeReg;
            w_busy_a = 1'b0;
        end
        if (!w_rdb_ok) begin
            w_rd_b   = '0;
            w_busy_b = 1'b0;
        end else if (BYPASS && w_wr_ok && (rf.ctrl_writeReg == rf.ctrl_readRegB)) begin
            w_rd_b   = rf.data_writeReg;
            w_busy_b = 1'b0;
        end
        // Keep forwarded data off the ports while reset is held.
        if (!ctrl_reset) begin
            w_rd_a   = '0;
            w_rd_b   = '0;
            w_busy_a = 1'b0;
            w_busy_b = 1'b0;
        end
    end

    assign rf.data_readRegA = w_rd_a;
    assign rf.data_readRegB = w_rd_b;
    assign rf.busy_readRegA = w_busy_a;
    assign rf.busy_readRegB = w_busy_b;
    assign rf.busy_vector   = w_pending;
    assign rf.data_regDbg   = r_regs[DBG_REG];

endmodule
